// File: rtl/spc_stack_ctrl_pkg.sv
// Shared widths and FSM state encoding for the subroutine-PC stack controller.
package spc_stack_ctrl_pkg;

    localparam int SPC_AW = 5;
    localparam int SPC_DW = 19;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DBG_RD   = 2'd1,
        ST_DBG_DONE = 2'd2
    } spc_state_e;

endpackage

// File: rtl/spc_ptr_unit.sv
// Next-state arithmetic for the stack pointer, depth counter and sticky flags.
// Purely combinational; the registers themselves live in spc_stack_ctrl.
module spc_ptr_unit
    import spc_stack_ctrl_pkg::*;
#(
    parameter int AW = SPC_AW
) (
    input  logic [AW-1:0] ptr_i,
    input  logic [AW:0]   depth_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic [AW-1:0] ptr_next_o,
    output logic [AW:0]   depth_next_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          clr_flags_o,
    output logic          set_ovf_o,
    output logic          set_unf_o
);

    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_FULL = {1'b1, {AW{1'b0}}};

    logic depth_empty;
    logic depth_full;

    assign depth_empty = (depth_i == '0);
    assign depth_full  = (depth_i == DEPTH_FULL);

    // Clear wins; replace-top writes in place, push writes one above, pop only moves the pointer.
    always_comb begin
        ptr_next_o   = ptr_i;
        depth_next_o = depth_i;
        wr_en_o      = 1'b0;
        wr_addr_o    = ptr_i;
        clr_flags_o  = 1'b0;
        set_ovf_o    = 1'b0;
        set_unf_o    = 1'b0;
        if (clear_i) begin
            ptr_next_o   = '0;
            depth_next_o = '0;
            clr_flags_o  = 1'b1;
        end else if (push_i && pop_i) begin
            wr_en_o   = 1'b1;
            wr_addr_o = ptr_i;
            if (depth_empty) begin
                depth_next_o = DEPTH_ONE;
                set_unf_o    = 1'b1;
            end
        end else if (push_i) begin
            ptr_next_o = ptr_i + PTR_ONE;
            wr_en_o    = 1'b1;
            wr_addr_o  = ptr_i + PTR_ONE;
            if (depth_full) begin
                set_ovf_o = 1'b1;
            end else begin
                depth_next_o = depth_i + DEPTH_ONE;
            end
        end else if (pop_i) begin
            ptr_next_o = ptr_i - PTR_ONE;
            if (depth_empty) begin
                set_unf_o = 1'b1;
            end else begin
                depth_next_o = depth_i - DEPTH_ONE;
            end
        end
    end

endmodule

// File: rtl/spc_stack_ctrl.sv
// Controller for the 32-entry subroutine-PC stack in front of a dual-port RAM.
// Port A only reads (top-of-stack prefetch and console reads); port B only writes.
module spc_stack_ctrl
    import spc_stack_ctrl_pkg::*;
#(
    parameter int AW = SPC_AW,
    parameter int DW = SPC_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    input  logic          clear,
    output logic          ready,
    output logic [DW-1:0] tos,
    output logic          tos_valid,
    output logic [AW-1:0] ptr,
    output logic [AW:0]   depth,
    output logic          overflow,
    output logic          underflow,
    input  logic          dbg_rd,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          dbg_ack,
    output logic [AW-1:0] ram_addr_a,
    output logic          ram_rden_a,
    input  logic [DW-1:0] ram_q_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [DW-1:0] ram_data_b,
    output logic          ram_wren_b
);

    spc_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   depth_q, depth_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          tos_valid_q;
    logic [DW-1:0] dbg_data_q, dbg_data_d;

    logic          push_acc;
    logic          pop_acc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          clr_flags;
    logic          set_ovf;
    logic          set_unf;

    assign ready    = (state_q == ST_IDLE) && !clear;
    assign push_acc = push && ready;
    assign pop_acc  = pop && ready;

    spc_ptr_unit #(
        .AW(AW)
    ) u_ptr_unit (
        .ptr_i       (ptr_q),
        .depth_i     (depth_q),
        .push_i      (push_acc),
        .pop_i       (pop_acc),
        .clear_i     (clear),
        .ptr_next_o  (ptr_d),
        .depth_next_o(depth_d),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .clr_flags_o (clr_flags),
        .set_ovf_o   (set_ovf),
        .set_unf_o   (set_unf)
    );

    // Sticky error flags: set by the pointer unit, dropped only by clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            overflow_d  = overflow_q | set_ovf;
            underflow_d = underflow_q | set_unf;
        end
    end

    // Arbitration FSM; port A prefetches the next top so tos is ready with no stall.
    always_comb begin
        state_d    = state_q;
        ram_addr_a = ptr_d;
        ram_rden_a = 1'b1;
        dbg_ack    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!clear && dbg_rd && !push && !pop) begin
                    state_d = ST_DBG_RD;
                end
            end
            ST_DBG_RD: begin
                ram_addr_a = dbg_addr;
                state_d    = ST_DBG_DONE;
            end
            ST_DBG_DONE: begin
                dbg_ack = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Console data is passed straight through during the ack and held afterwards.
    always_comb begin
        dbg_data_d = dbg_data_q;
        if (dbg_ack) begin
            dbg_data_d = ram_q_a;
        end
    end

    // State registers; tos_valid_q marks that at least one clock has passed since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            tos_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            tos_valid_q <= 1'b1;
            dbg_data_q  <= dbg_data_d;
        end
    end

    assign tos        = ram_q_a;
    assign tos_valid  = tos_valid_q && (state_q != ST_DBG_DONE);
    assign ptr        = ptr_q;
    assign depth      = depth_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign dbg_data   = dbg_data_d;
    assign ram_addr_b = wr_addr;
    assign ram_data_b = push_data;
    assign ram_wren_b = wr_en && reset_n;

endmodule

// File: tb/tb_spc_stack_ctrl.sv
// Scoreboard bench for spc_stack_ctrl with a behavioural 32x19 dual-port RAM.
module tb_spc_stack_ctrl;

    localparam int AW = 5;
    localparam int DW = 19;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic          clear;
    logic          ready;
    logic [DW-1:0] tos;
    logic          tos_valid;
    logic [AW-1:0] ptr;
    logic [AW:0]   depth;
    logic          overflow;
    logic          underflow;
    logic          dbg_rd;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ack;
    logic [AW-1:0] ram_addr_a;
    logic          ram_rden_a;
    logic [DW-1:0] ram_q_a = '0;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_wren_b;

    typedef struct {
        int            ptr;
        int            depth;
        bit            ovf;
        bit            unf;
        bit            tv;
        logic [DW-1:0] tos;
        bit            ack;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] dbgQ[$];

    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] ramMem [DEPTH];
    logic [DW-1:0] mMem [DEPTH];
    int            mPtr;
    int            mDepth;
    bit            mOvf;
    bit            mUnf;
    int            mBusy;
    bit            lastWasDone;
    bit            haveDbg;
    logic [DW-1:0] lastDbg;

    always #5 clk = ~clk;

    spc_stack_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clear     (clear),
        .ready     (ready),
        .tos       (tos),
        .tos_valid (tos_valid),
        .ptr       (ptr),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow),
        .dbg_rd    (dbg_rd),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_ack   (dbg_ack),
        .ram_addr_a(ram_addr_a),
        .ram_rden_a(ram_rden_a),
        .ram_q_a   (ram_q_a),
        .ram_addr_b(ram_addr_b),
        .ram_data_b(ram_data_b),
        .ram_wren_b(ram_wren_b)
    );

    // RAM model: registered port A read with read-new-data on a same-address port B write.
    always @(posedge clk) begin
        if (ram_rden_a) begin
            if (ram_wren_b && (ram_addr_b == ram_addr_a)) begin
                ram_q_a <= ram_data_b;
            end else begin
                ram_q_a <= ramMem[ram_addr_a];
            end
        end
        if (ram_wren_b) begin
            ramMem[ram_addr_b] <= ram_data_b;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs, advance the stack model and queue what the DUT must show after the edge.
    task automatic applyStimulus(input logic iPush, input logic iPop, input logic [DW-1:0] iData,
                                 input logic iClear, input logic iDbg, input logic [AW-1:0] iAddr);
        exp_t e;
        bit   rdy;
        int   wrAddr;
        @(negedge clk);
        push      = iPush;
        pop       = iPop;
        push_data = iData;
        clear     = iClear;
        dbg_rd    = iDbg;
        dbg_addr  = iAddr;
        rdy       = (mBusy == 0) && !iClear;
        wrAddr    = (iPush && iPop) ? mPtr : (mPtr + 1) % DEPTH;
        #1;
        checkOutput("ready", 32'(ready), 32'(rdy));
        checkOutput("wren_b", 32'(ram_wren_b), 32'(rdy && iPush));
        if (rdy && iPush) begin
            checkOutput("addr_b", 32'(ram_addr_b), 32'(wrAddr));
            checkOutput("data_b", 32'(ram_data_b), 32'(iData));
        end
        if (iClear) begin
            mPtr   = 0;
            mDepth = 0;
            mOvf   = 0;
            mUnf   = 0;
        end else if (rdy && iPush && iPop) begin
            mMem[mPtr] = iData;
            if (mDepth == 0) begin
                mDepth = 1;
                mUnf   = 1;
            end
        end else if (rdy && iPush) begin
            mPtr       = (mPtr + 1) % DEPTH;
            mMem[mPtr] = iData;
            if (mDepth == DEPTH) mOvf = 1;
            else mDepth = mDepth + 1;
        end else if (rdy && iPop) begin
            mPtr = (mPtr + DEPTH - 1) % DEPTH;
            if (mDepth == 0) mUnf = 1;
            else mDepth = mDepth - 1;
        end
        lastWasDone = (mBusy == 1);
        if (mBusy > 0) begin
            mBusy = mBusy - 1;
        end else if (!iClear && iDbg && !iPush && !iPop) begin
            mBusy = 2;
            dbgQ.push_back(mMem[iAddr]);
        end
        e.ptr   = mPtr;
        e.depth = mDepth;
        e.ovf   = mOvf;
        e.unf   = mUnf;
        e.tv    = (mBusy != 1);
        e.tos   = mMem[mPtr];
        e.ack   = (mBusy == 1);
        expQ.push_back(e);
    endtask

    // Asynchronous reset pulse starting at a falling edge; RAM contents survive it.
    task automatic applyReset();
        @(negedge clk);
        reset_n   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        dbg_rd    = 1'b0;
        push_data = '0;
        dbg_addr  = '0;
        expQ.delete();
        dbgQ.delete();
        mPtr    = 0;
        mDepth  = 0;
        mOvf    = 0;
        mUnf    = 0;
        mBusy   = 0;
        haveDbg = 0;
        #1;
        checkOutput("rst_ptr", 32'(ptr), 32'd0);
        checkOutput("rst_depth", 32'(depth), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_unf", 32'(underflow), 32'd0);
        checkOutput("rst_tos_valid", 32'(tos_valid), 32'd0);
        checkOutput("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        checkOutput("rst_wren_b", 32'(ram_wren_b), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("tos_valid_first", 32'(tos_valid), 32'd0);
    endtask

    // Monitor: after every edge, pop the queued expectation and compare the visible state.
    always @(posedge clk) begin
        exp_t          e;
        logic [DW-1:0] expDbg;
        #1;
        if (reset_n && (expQ.size() > 0)) begin
            e = expQ.pop_front();
            checkOutput("ptr", 32'(ptr), 32'(e.ptr));
            checkOutput("depth", 32'(depth), 32'(e.depth));
            checkOutput("overflow", 32'(overflow), 32'(e.ovf));
            checkOutput("underflow", 32'(underflow), 32'(e.unf));
            checkOutput("tos_valid", 32'(tos_valid), 32'(e.tv));
            if (e.tv) checkOutput("tos", 32'(tos), 32'(e.tos));
            checkOutput("dbg_ack", 32'(dbg_ack), 32'(e.ack));
            if (e.ack && (dbgQ.size() > 0)) begin
                expDbg = dbgQ.pop_front();
                checkOutput("dbg_data", 32'(dbg_data), 32'(expDbg));
                lastDbg = expDbg;
                haveDbg = 1;
            end else if (haveDbg) begin
                checkOutput("dbg_hold", 32'(dbg_data), 32'(lastDbg));
            end
        end
    end

    initial begin
        bit            dbgReq;
        logic [AW-1:0] dbgAddr;
        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i] = '0;
            mMem[i]   = '0;
        end
        reset_n   = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        dbg_rd    = 1'b0;
        push_data = '0;
        dbg_addr  = '0;
        applyReset();

        // Three pushes then four pops, the last one underflowing.
        applyStimulus(1'b1, 1'b0, 19'o1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o2, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o3, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (4) applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);

        // Clear, then 33 pushes to overflow and wrap onto the oldest entry.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        for (int v = 1; v <= 33; v++) applyStimulus(1'b1, 1'b0, DW'(v), 1'b0, 1'b0, '0);

        // Replace-top at depth 2.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o11, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o22, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 19'o777, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Console read of address 2 with a push attempted during the read.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 5'd2);
        applyStimulus(1'b1, 1'b0, 19'o555, 1'b0, 1'b1, 5'd2);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 5'd2);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Clear together with a push at depth 5.
        applyStimulus(1'b1, 1'b0, 19'o31, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o32, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o33, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 19'o4444, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Reset pulse while the console read is in flight, then replace-top on an empty stack.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 5'd1);
        applyReset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 19'o1234, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Random mix with a level console request held until its ack cycle.
        dbgReq  = 1'b0;
        dbgAddr = '0;
        for (int i = 0; i < 800; i++) begin
            if (!dbgReq && ($urandom_range(5) == 0)) begin
                dbgReq  = 1'b1;
                dbgAddr = AW'($urandom);
            end
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), DW'($urandom),
                          ($urandom_range(24) == 0), dbgReq, dbgAddr);
            if (lastWasDone) dbgReq = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        @(posedge clk);
        #2;
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
